addr_hazard_unit: RTL
=====================

# addr_hazard_unit

Parametrised RAW hazard detection and forwarding-select unit for the 5-stage MIPS pipeline, evaluated against the instruction in IF/ID. Keeps a shift-register scoreboard of in-flight destination registers, one entry per downstream stage. For each source operand it selects the youngest in-flight producer, or requests a one-cycle load-use stall. Supersedes the single-stage, load-address-only forward flag with DEPTH stages, an rs/rt operand pair, a selectable mode and a stall counter.

## Interface
- DEPTH, 3: in-flight stages tracked; entry 1 = EX, 2 = MEM, 3 = WB; legal range 2..7.
- FWD_MODE, 1: 0 = address-only, covering rs of lw/sw only; 1 = full, covering rs and rt of all instructions.
- CNT_W, 16: width of the stall counter.
- SEL_W, derived as $clog2(DEPTH+1); not user-set.

Ports (clock and reset first):
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_instr  in  32  instruction currently in IF/ID.
- id_valid  in  1  id_instr holds a real instruction.
- flush  in  1  kill the IF/ID instruction; a bubble enters EX.
- fwd_sel_rs  out  SEL_W  0 = register file; k = forward from entry k.
- fwd_sel_rt  out  SEL_W  same encoding, for rt.
- stall  out  1  load-use hazard; hold PC and IF/ID, insert a bubble.
- stall_count  out  CNT_W  saturating count of cycles with stall high.

## Operation
Decode (combinational, from id_instr):
- opcode 0 writes rd. Exception: funct 001000 (jr) writes nothing.
- Opcode 100011 (lw) writes rt and marks the entry is_load.
- Opcodes 001xxx write rt.
- Opcode 000011 (jal) writes register 31.
- sw, beq, bne and j write nothing.
- rs is used by: R-type, 001xxx except lui (001111), lw, sw, beq, bne.
- rt is used by: R-type, sw, beq, bne.
- Destination 0 never creates an entry. Source 0 never matches.

Scoreboard entries 1..DEPTH each hold {valid, dst[4:0], is_load}.

Each rising edge:
- Entries k = 2..DEPTH load the old entry k-1.
- Entry 1 loads the decoded IF/ID instruction only when id_valid=1, flush=0, stall=0 and the instruction writes a nonzero register.
- Otherwise entry 1 is loaded invalid (a bubble).

Match (per operand, combinational):
- Find the smallest k with valid[k]=1 and dst[k] equal to the source; the youngest producer wins.
- If the match is k=1 and is_load=1: assert stall and drive the select to 0.
- Otherwise drive the select to k, or to 0 when there is no match.

Gating:
- FWD_MODE=0: fwd_sel_rt is always 0. rs is evaluated only for lw/sw; fwd_sel_rs is 0 for all other instructions.
- stall = OR of the per-operand load-use conditions, masked by id_valid and !flush.
- When id_valid=0 or flush=1, stall and both selects are 0.

stall_count increments on every edge where stall=1 and saturates at all-ones.

## Timing
- Outputs are combinational from id_instr and registered scoreboard state; zero-cycle latency.
- Scoreboard latency: an instruction accepted at edge n is entry 1 during cycle n+1 and entry k during cycle n+k.
- A stall lasts exactly one cycle per load-use pair. The bubble in entry 1 moves the load to entry 2, so on the next cycle stall drops and the select becomes 2.
- Simultaneous stall and flush: flush wins; no stall is reported and a bubble is inserted.
- Reset (asynchronous, any time): all valid bits and stall_count go to 0 immediately. Therefore stall=0, fwd_sel_rs=0 and fwd_sel_rt=0 while reset_n=0 and after release until new entries arrive.
- Mid-operation reset discards every in-flight entry; no forwarding references survive.

## Test plan
- Reset: hold reset_n=0 with id_valid=1 and lw $8,0($9) presented -> stall=0, fwd_sel_rs=0, fwd_sel_rt=0, stall_count=0.
- EX forward: ori $9,$0,0xff then lw $8,0($9) on consecutive cycles -> fwd_sel_rs=1, stall=0.
- Load-use: lw $9,0($1) then add $3,$4,$9 -> one cycle stall=1 with fwd_sel_rt=0, then fwd_sel_rt=2, stall=0; stall_count=1.
- Youngest wins: addi $5 (cycle 1), addi $5 (cycle 2), sub $6,$5,$5 (cycle 3) -> fwd_sel_rs=fwd_sel_rt=1, never 2.
- Mode and zero register: FWD_MODE=0, add $2,$0,$0 after addi $3,... then add $4,$3,$3 -> fwd_sel_rt=0 and fwd_sel_rs=0 (not a memory op); a write to $0 followed by a read of $0 -> select 0.
- Flush and saturation: flush=1 with a load-use pair presented -> stall=0 and entry 1 becomes a bubble. With CNT_W=2, four stall cycles -> stall_count=3 and held there.

Source files
------------

// File: rtl/addr_hazard_unit.sv
// rtl/addr_hazard_unit.sv - RAW hazard scoreboard with forwarding select and load-use stall
module addr_hazard_unit #(
    parameter  int DEPTH    = 3,
    parameter  int FWD_MODE = 1,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_sel_rs,
    output logic [SEL_W-1:0] fwd_sel_rt,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op    = id_instr[31:26];
    assign rs    = id_instr[25:21];
    assign rt    = id_instr[20:16];
    assign rd    = id_instr[15:11];
    assign funct = id_instr[5:0];

    logic [DEPTH:1] sb_valid;
    logic [DEPTH:1] sb_load;
    logic [4:0]     sb_dst [1:DEPTH];

    logic       wr_en;
    logic       wr_load;
    logic [4:0] wr_dst;
    logic       is_rtype;
    logic       is_imm;
    logic       is_mem;
    logic       is_branch;
    logic       use_rs;
    logic       use_rt;

    always_comb begin
        wr_en   = 1'b0;
        wr_load = 1'b0;
        wr_dst  = rd;
        if (op == OP_RTYPE) begin
            wr_en  = (funct != FN_JR);
            wr_dst = rd;
        end else if (op == OP_LW) begin
            wr_en   = 1'b1;
            wr_load = 1'b1;
            wr_dst  = rt;
        end else if (op[5:3] == 3'b001) begin
            wr_en  = 1'b1;
            wr_dst = rt;
        end else if (op == OP_JAL) begin
            wr_en  = 1'b1;
            wr_dst = 5'd31;
        end
    end

    assign is_rtype  = (op == OP_RTYPE);
    assign is_imm    = (op[5:3] == 3'b001) && (op != OP_LUI);
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);

    // Address-only mode looks at the base register of loads/stores and nothing else.
    assign use_rs = (FWD_MODE != 0) ? (is_rtype || is_imm || is_mem || is_branch) : is_mem;
    assign use_rt = (FWD_MODE != 0) && (is_rtype || (op == OP_SW) || is_branch);

    logic [SEL_W-1:0] hit_rs;
    logic [SEL_W-1:0] hit_rt;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb_valid[k] && (sb_dst[k] == rs) && (rs != 5'd0)) hit_rs = SEL_W'(k);
            if (sb_valid[k] && (sb_dst[k] == rt) && (rt != 5'd0)) hit_rt = SEL_W'(k);
        end
    end

    logic live;
    logic lu_rs;
    logic lu_rt;
    logic accept;

    assign live   = id_valid && !flush;
    assign lu_rs  = use_rs && (hit_rs == SEL_W'(1)) && sb_load[1];
    assign lu_rt  = use_rt && (hit_rt == SEL_W'(1)) && sb_load[1];
    assign stall  = live && (lu_rs || lu_rt);
    assign accept = live && !stall && wr_en && (wr_dst != 5'd0);

    assign fwd_sel_rs = (live && use_rs && !lu_rs) ? hit_rs : '0;
    assign fwd_sel_rt = (live && use_rt && !lu_rt) ? hit_rt : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb_valid    <= '0;
            sb_load     <= '0;
            stall_count <= '0;
            for (int k = 1; k <= DEPTH; k++) sb_dst[k] <= 5'd0;
        end else begin
            for (int k = 2; k <= DEPTH; k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_dst[k]   <= sb_dst[k-1];
            end
            sb_valid[1] <= accept;
            sb_load[1]  <= accept && wr_load;
            sb_dst[1]   <= wr_dst;
            if (stall && (stall_count != {CNT_W{1'b1}})) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
